// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, memory request/response, decode handoff
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req_valid/ready/addr        word fetch request to instruction memory
//   imem_resp_valid/data/err         read response, one pulse per accepted request
//   inst_valid/ready, inst, inst_pc  fetched instruction presented to decode
//   redirect_valid, redirect_pc      control-flow change
//   halt                             stop fetching after the current instruction
//   halted, fetch_fault              sticky stop status

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        req_valid_q;
    logic [31:0] req_addr_q;
    logic        inst_valid_q;
    logic        halted_q;
    logic        fault_q;

    logic        req_hs;
    logic        redir_bad;

    assign req_hs    = req_valid_q & imem_req_ready;
    assign redir_bad = redirect_pc[1:0] != 2'b00;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (redirect_valid) begin
                    if (redir_bad) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d = redirect_pc;
                        // Request already accepted for the old pc: its response must be dropped.
                        if (req_hs) begin
                            discard_d = 1'b1;
                            state_d   = S_WAIT;
                        end
                    end
                end else if (req_hs) begin
                    state_d = S_WAIT;
                end else if (halt) begin
                    state_d = S_HALT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    if (redir_bad) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d = redirect_pc;
                        // A response landing with the redirect closes the outstanding
                        // request, so nothing is left to discard.
                        if (imem_resp_valid) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            discard_d = 1'b1;
                        end
                    end
                end else if (imem_resp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else if (halt) begin
                        state_d = S_HALT;
                    end else if (imem_resp_err) begin
                        state_d = S_FAULT;
                    end else begin
                        inst_d    = imem_resp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_OUT;
                    end
                end
            end
            S_OUT: begin
                // Redirect wins over consumption: pc takes the target, not pc+4.
                if (redirect_valid) begin
                    if (redir_bad) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = S_REQ;
                    end
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = halt ? S_HALT : S_REQ;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= RESET_PC;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            req_valid_q  <= state_d == S_REQ;
            req_addr_q   <= pc_d;
            inst_valid_q <= state_d == S_OUT;
            halted_q     <= state_d == S_HALT;
            fault_q      <= state_d == S_FAULT;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign halted         = halted_q;
    assign fetch_fault    = fault_q;

endmodule
